// File: rtl/ram_port_arbiter.sv
// Arbitrates the single-port data RAM between the CPU memory stage and a
// secondary device read port. CPU access is gated behind the start switch,
// and absolute addresses are mapped onto RAM-local word indices.
module ram_port_arbiter #(
    parameter int unsigned RAM_BASE     = 8500,
    parameter int unsigned RAM_DEPTH    = 1024,
    parameter int unsigned AW           = 10,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          switchStart,
    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [31:0]   cpu_addr,
    input  logic [31:0]   cpu_wdata,
    output logic          cpu_stall,
    output logic [31:0]   cpu_rdata,
    output logic          cpu_rvalid,
    input  logic          dev_req,
    input  logic [31:0]   dev_addr,
    output logic          dev_gnt,
    output logic [31:0]   dev_rdata,
    output logic          dev_rvalid,
    output logic          ram_we,
    output logic [AW-1:0] ram_addr,
    output logic [31:0]   ram_wdata,
    input  logic [31:0]   ram_rdata,
    output logic          running,
    output logic          addr_err
);

    localparam int unsigned SW = $clog2(STARVE_LIMIT + 1);
    localparam logic [SW-1:0] StarveMax = SW'(STARVE_LIMIT);
    localparam logic [31:0] RamEnd = RAM_BASE + RAM_DEPTH;

    typedef enum logic {StWaitStart, StRun} state_e;

    state_e          state_q, state_d;
    logic [SW-1:0]   starve_q, starve_d;
    logic            tag_valid_q, tag_valid_d;
    logic            tag_cpu_q, tag_cpu_d;
    logic            tag_oor_q, tag_oor_d;
    logic [AW-1:0]   addr_q;

    logic            cpu_grant;
    logic            dev_grant;
    logic            any_grant;
    logic [31:0]     sel_addr;
    logic [AW-1:0]   local_addr;
    logic            in_range;

    assign running = (state_q == StRun);

    // Start-switch FSM state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StWaitStart;
        end else begin
            state_q <= state_d;
        end
    end

    // Start-switch FSM next state: RUN is absorbing until reset.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StWaitStart: if (switchStart) state_d = StRun;
            StRun:       state_d = StRun;
            default:     state_d = StWaitStart;
        endcase
    end

    // Grant selection, address decode and RAM drive for the current cycle.
    always_comb begin
        cpu_grant  = 1'b0;
        dev_grant  = 1'b0;
        // Both grants are held off during reset so nothing reaches the RAM.
        if (!reset) begin
            cpu_grant = cpu_req && running && !(dev_req && (starve_q == StarveMax));
            dev_grant = dev_req && !cpu_grant;
        end
        any_grant  = cpu_grant || dev_grant;
        sel_addr   = cpu_grant ? cpu_addr : dev_addr;
        local_addr = AW'(sel_addr - RAM_BASE);
        in_range   = (sel_addr >= RAM_BASE) && (sel_addr < RamEnd);

        cpu_stall  = cpu_req && !cpu_grant;
        dev_gnt    = dev_grant;
        ram_we     = cpu_grant && cpu_we && in_range;
        ram_addr   = any_grant ? local_addr : addr_q;
        ram_wdata  = cpu_wdata;
        addr_err   = any_grant && !in_range;
    end

    // Next-state for the starvation counter and the read-return tag.
    always_comb begin
        starve_d = starve_q;
        if (dev_grant || !dev_req) begin
            starve_d = '0;
        end else if (cpu_grant && (starve_q != StarveMax)) begin
            starve_d = starve_q + 1'b1;
        end

        tag_valid_d = (cpu_grant && !cpu_we) || dev_grant;
        tag_cpu_d   = cpu_grant;
        tag_oor_d   = !in_range;
    end

    // Starvation counter, read tag and last-address registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            starve_q    <= '0;
            tag_valid_q <= 1'b0;
            tag_cpu_q   <= 1'b0;
            tag_oor_q   <= 1'b0;
            addr_q      <= '0;
        end else begin
            starve_q    <= starve_d;
            tag_valid_q <= tag_valid_d;
            tag_cpu_q   <= tag_cpu_d;
            tag_oor_q   <= tag_oor_d;
            if (any_grant) addr_q <= local_addr;
        end
    end

    // Read return: the tag owner gets RAM data (zero when out of range),
    // and a reset arriving in the return cycle kills the response.
    always_comb begin
        cpu_rvalid = tag_valid_q && tag_cpu_q && !reset;
        dev_rvalid = tag_valid_q && !tag_cpu_q && !reset;
        cpu_rdata  = (cpu_rvalid && !tag_oor_q) ? ram_rdata : 32'd0;
        dev_rdata  = (dev_rvalid && !tag_oor_q) ? ram_rdata : 32'd0;
    end

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Randomized bench for ram_port_arbiter with a behavioural RAM macro and an
// abstract transaction-level reference model.
module tb_ram_port_arbiter;

    localparam int unsigned BASE  = 8500;
    localparam int unsigned DEPTH = 1024;
    localparam int unsigned LIMIT = 4;

    logic        clk = 1'b0;
    logic        reset, switchStart;
    logic        cpu_req, cpu_we, dev_req;
    logic [31:0] cpu_addr, cpu_wdata, dev_addr;
    logic        cpu_stall, cpu_rvalid, dev_gnt, dev_rvalid;
    logic [31:0] cpu_rdata, dev_rdata, ram_wdata, ram_rdata;
    logic        ram_we, running, addr_err;
    logic [9:0]  ram_addr;

    always #5 clk = ~clk;

    ram_port_arbiter #(
        .RAM_BASE(BASE), .RAM_DEPTH(DEPTH), .AW(10), .STARVE_LIMIT(LIMIT)
    ) dut (
        .clk(clk), .reset(reset), .switchStart(switchStart),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_stall(cpu_stall), .cpu_rdata(cpu_rdata), .cpu_rvalid(cpu_rvalid),
        .dev_req(dev_req), .dev_addr(dev_addr), .dev_gnt(dev_gnt),
        .dev_rdata(dev_rdata), .dev_rvalid(dev_rvalid),
        .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
        .running(running), .addr_err(addr_err)
    );

    // RAM macro: synchronous write, registered read.
    logic [31:0] ram_mem [DEPTH];
    always @(posedge clk) begin
        if (ram_we) ram_mem[ram_addr] <= ram_wdata;
        ram_rdata <= ram_mem[ram_addr];
    end

    // Reference model state.
    bit          m_run;
    int          m_starve;
    logic [31:0] m_mem [DEPTH];
    bit          p_valid, p_cpu;
    logic [31:0] p_data;
    bit          last_cg, last_dg;
    logic        obs_gnt, obs_stall, obs_err, obs_we;
    logic [31:0] obs_rdata;
    logic        obs_rvalid;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // One clock cycle: drive inputs, compare every output with the model,
    // then advance the model across the coming rising edge.
    task automatic step(input bit rst, input bit sw, input bit creq, input bit cwe,
                        input logic [31:0] caddr, input logic [31:0] cwd,
                        input bit dreq, input logic [31:0] daddr);
        bit          cg, dg, inr;
        logic [31:0] a, off;
        @(negedge clk);
        reset = rst; switchStart = sw;
        cpu_req = creq; cpu_we = cwe; cpu_addr = caddr; cpu_wdata = cwd;
        dev_req = dreq; dev_addr = daddr;
        #1;
        obs_gnt = dev_gnt; obs_stall = cpu_stall; obs_err = addr_err; obs_we = ram_we;
        obs_rdata = cpu_rdata; obs_rvalid = cpu_rvalid;
        check("running", running, m_run);
        if (rst) begin
            check("rst_stall", cpu_stall, creq);
            check("rst_gnt", dev_gnt, 0);
            check("rst_we", ram_we, 0);
            check("rst_err", addr_err, 0);
            check("rst_crv", cpu_rvalid, 0);
            check("rst_drv", dev_rvalid, 0);
            m_run = 0; m_starve = 0; p_valid = 0; last_cg = 0; last_dg = 0;
            return;
        end
        cg = creq && m_run && !(dreq && m_starve == LIMIT);
        dg = dreq && !cg;
        check("cpu_rvalid", cpu_rvalid, p_valid && p_cpu);
        check("cpu_rdata", cpu_rdata, (p_valid && p_cpu) ? p_data : 32'd0);
        check("dev_rvalid", dev_rvalid, p_valid && !p_cpu);
        check("dev_rdata", dev_rdata, (p_valid && !p_cpu) ? p_data : 32'd0);
        check("cpu_stall", cpu_stall, creq && !cg);
        check("dev_gnt", dev_gnt, dg);
        a   = cg ? caddr : daddr;
        inr = (a >= BASE) && (a < BASE + DEPTH);
        off = (a - BASE) % DEPTH;
        check("ram_we", ram_we, cg && cwe && inr);
        check("addr_err", addr_err, (cg || dg) && !inr);
        if (cg || dg) check("ram_addr", ram_addr, off);
        if (cg && cwe) check("ram_wdata", ram_wdata, cwd);
        // Advance the model.
        p_valid = (cg && !cwe) || dg;
        p_cpu   = cg;
        p_data  = inr ? m_mem[off] : 32'd0;
        if (cg && cwe && inr) m_mem[off] = cwd;
        if (dg || !dreq) m_starve = 0;
        else if (cg && m_starve < LIMIT) m_starve++;
        m_run   = m_run || sw;
        last_cg = cg; last_dg = dg;
    endtask

    function automatic logic [31:0] rand_addr();
        case ($urandom_range(0, 7))
            0: return BASE - 1;
            1: return BASE;
            2: return BASE + DEPTH - 1;
            3: return BASE + DEPTH;
            4: return $urandom;
            default: return BASE + $urandom_range(0, 63);
        endcase
    endfunction

    bit          r_creq, r_cwe, r_dreq;
    logic [31:0] r_caddr, r_cwd, r_daddr;

    initial begin
        for (int i = 0; i < DEPTH; i++) begin
            ram_mem[i] = 32'd0;
            m_mem[i]   = 32'd0;
        end
        reset = 1; switchStart = 0; cpu_req = 0; cpu_we = 0; cpu_addr = 0; cpu_wdata = 0;
        dev_req = 0; dev_addr = 0;
        m_run = 0; m_starve = 0; p_valid = 0; p_cpu = 0; p_data = 0;

        // Start gating.
        step(1, 0, 1, 1, 8501, 33, 0, 0);
        for (int i = 0; i < 3; i++) begin
            step(0, 0, 1, 1, 8501, 33, 0, 0);
            check("gate_stall", obs_stall, 1);
            check("gate_we", obs_we, 0);
        end
        step(0, 1, 1, 1, 8501, 33, 0, 0);
        check("sw_edge_stall", obs_stall, 1);
        step(0, 0, 1, 1, 8501, 33, 0, 0);
        check("start_running", running, 1);
        check("start_write", obs_we, 1);

        // Read latency.
        step(0, 0, 1, 1, 8500, 45, 0, 0);
        step(0, 0, 1, 0, 8500, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0);
        check("rd_valid", obs_rvalid, 1);
        check("rd_data", obs_rdata, 45);

        // Out of range.
        step(0, 0, 1, 1, 400, 222, 0, 0);
        check("oor_err_wr", obs_err, 1);
        check("oor_we", obs_we, 0);
        step(0, 0, 1, 0, 9524, 0, 0, 0);
        check("oor_err_rd", obs_err, 1);
        step(0, 0, 0, 0, 0, 0, 0, 0);
        check("oor_rvalid", obs_rvalid, 1);
        check("oor_rdata", obs_rdata, 0);

        // Starvation: four CPU grants, DEV on the fifth, CPU on the sixth.
        for (int i = 1; i <= 6; i++) begin
            step(0, 0, 1, 0, 8501, 0, 1, 8502);
            check("starve_gnt", obs_gnt, (i == 5) ? 1 : 0);
            check("starve_stall", obs_stall, (i == 5) ? 1 : 0);
        end
        step(0, 0, 0, 0, 0, 0, 0, 0);

        // DEV preload in WAIT_START, then reset right after a CPU read grant.
        step(1, 0, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 1, 8502);
        check("pre_gnt", obs_gnt, 1);
        step(0, 0, 0, 0, 0, 0, 0, 0);
        check("pre_rvalid", dev_rvalid, 1);
        step(0, 1, 0, 0, 0, 0, 0, 0);
        step(0, 0, 1, 0, 8500, 0, 0, 0);
        step(1, 0, 1, 0, 8500, 0, 0, 0);
        check("rst_kill_rv", obs_rvalid, 0);
        step(0, 0, 1, 0, 8500, 0, 0, 0);
        check("rst_running", running, 0);
        check("rst_stall_follow", obs_stall, 1);

        // Randomized traffic; requests are held until granted.
        r_creq = 0; r_dreq = 0; r_cwe = 0; r_caddr = 0; r_cwd = 0; r_daddr = 0;
        for (int n = 0; n < 3000; n++) begin
            if (!r_creq) begin
                r_creq  = $urandom_range(0, 2) != 0;
                r_cwe   = $urandom_range(0, 1) != 0;
                r_caddr = rand_addr();
                r_cwd   = $urandom;
            end
            if (!r_dreq) begin
                r_dreq  = $urandom_range(0, 2) == 0;
                r_daddr = rand_addr();
            end
            step($urandom_range(0, 299) == 0, $urandom_range(0, 19) == 0,
                 r_creq, r_cwe, r_caddr, r_cwd, r_dreq, r_daddr);
            if (last_cg) r_creq = 0;
            if (last_dg) r_dreq = 0;
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
